mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle MIPS main control FSM, upstream of RegFile, ALU, PC and memory.
//  Sequences fetch/decode/execute/memory/writeback for each instruction.
//  Drives RegFile RegRead/RegWrite/RegDst/MemtoReg and all datapath mux selects.
//  Moore machine: controls decode from the state register only.
// PARAMETERS
//  ADDI_EN  1  1: addi (001000) supported; 0: addi decodes as illegal
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26]; stable from end of FETCH until next FETCH
//  state        out  4  current state encoding (debug)
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU zero
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  IorD         out  1  memory address: 0 PC, 1 ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  instruction register load
//  RegRead      out  1  RegFile read enable
//  RegWrite     out  1  RegFile write enable
//  RegDst       out  1  write reg: 0 rt, 1 rd
//  MemtoReg     out  1  write data: 0 ALUOut, 1 MDR
//  ALUSrcA      out  1  0 PC, 1 regA
//  ALUSrcB      out  2  00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUOp        out  2  00 add, 01 sub, 10 funct-decoded
//  instr_done   out  1  1-cycle pulse in final state of each instruction
//  illegal_op   out  1  1-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEM_ADDR2 MEM_READ3 MEM_WB4 MEM_WRITE5 EXECUTE6
//   ALU_WB7 BRANCH8 JUMP9 ADDI_EX10 ADDI_WB11; codes 12-15 unused.
//  Controls not listed for a state are 0 (one-hot strobes never overlap).
//  FETCH: MemRead IRWrite PCWrite, IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00 -> DECODE
//  DECODE: RegRead, ALUSrcA=0 ALUSrcB=11 ALUOp=00; next on opcode:
//   000000->EXECUTE; 100011/101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP;
//   001000->ADDI_EX (if ADDI_EN); else ->FETCH with illegal_op=1, instr_done=0
//  MEM_ADDR: ALUSrcA=1 ALUSrcB=10 ALUOp=00 -> MEM_READ (lw) / MEM_WRITE (sw)
//  MEM_READ: MemRead IorD=1 -> MEM_WB
//  MEM_WB: RegWrite MemtoReg=1 RegDst=0, instr_done -> FETCH
//  MEM_WRITE: MemWrite IorD=1, instr_done -> FETCH
//  EXECUTE: ALUSrcA=1 ALUSrcB=00 ALUOp=10 -> ALU_WB
//  ALU_WB: RegWrite RegDst=1 MemtoReg=0, instr_done -> FETCH
//  BRANCH: PCWriteCond ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCSource=01, instr_done -> FETCH
//  JUMP: PCWrite PCSource=10, instr_done -> FETCH
//  ADDI_EX: ALUSrcA=1 ALUSrcB=10 ALUOp=00 -> ADDI_WB
//  ADDI_WB: RegWrite RegDst=0 MemtoReg=0, instr_done -> FETCH
//  Latency (cycles FETCH..done): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  opcode sampled only in DECODE and MEM_ADDR; changes elsewhere ignored.
//  Reset: state<=FETCH on next edge; while reset=1 every output forced 0,
//   state reads 0; first FETCH strobes appear the cycle after reset falls.
//  Reset mid-instruction aborts it: no RegWrite/MemWrite/PCWrite issued, no instr_done.
//  Unused codes 12-15 (upset): outputs 0, next state FETCH.
// STRUCTURE
//  mips_defs.vh: state codes, opcode constants, ALUOp/PCSource/ALUSrcB encodings;
//   shared with ALU control and datapath.
//  Sub-module mips_mc_ctrl_decode: combinational state->control outputs.
//  Top: state register, next-state logic, reset gating.
// TESTING
//  reset=1 2 cycles with opcode=100011 -> all outputs 0, state=0; release -> FETCH strobes.
//  lw (100011) -> states 0,1,2,3,4; RegWrite=1 MemtoReg=1 only cycle 5; instr_done once.
//  R-type, then beq, then j back-to-back -> 4+3+3 cycles; ALUOp 10,01; PCSource 01,10.
//  sw -> MemWrite=1 IorD=1 only in cycle 4; RegWrite never 1.
//  opcode=111111 -> DECODE illegal_op=1, back to FETCH; ADDI_EN=0 with 001000 same.
//  reset asserted in MEM_READ of lw -> next cycle state=0, no RegWrite, no instr_done.

Source files
------------

// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multicycle MIPS main control.
//   state_t : FSM state codes (0-11 used, 12-15 unused)
//   OP_*    : opcode constants (IR[31:26])
//   ALUOP_* / PCSRC_* / SRCB_* : datapath mux encodings, shared with
//             ALU control and datapath
//   ctrl_t  : bundle of datapath control strobes decoded from the state
//   isLegal : opcode support check, gated by the addi enable
package mips_mc_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic [1:0] pcSource;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       regRead;
      logic       regWrite;
      logic       regDst;
      logic       memtoReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       instrDone;
   } ctrl_t;

   function automatic logic isLegal(input logic [5:0] op, input logic addiEn);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         OP_ADDI:                              ok = addiEn;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bus between the main control FSM and the datapath.
//   opcode         : IR[31:26] from datapath
//   state          : current FSM state (debug)
//   PCWrite..ALUOp : datapath control strobes and mux selects
//   instr_done     : pulse in the last state of each instruction
//   illegal_op     : pulse in DECODE on an unsupported opcode
// master = control FSM, slave = datapath.
interface mips_mc_control_if;
   logic [5:0] opcode;
   logic [3:0] state;
   logic       PCWrite;
   logic       PCWriteCond;
   logic [1:0] PCSource;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegRead;
   logic       RegWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  opcode,
      output state, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
             IRWrite, RegRead, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
             ALUOp, instr_done, illegal_op
   );

   modport slave (
      output opcode,
      input  state, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
             IRWrite, RegRead, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
             ALUOp, instr_done, illegal_op
   );
endinterface

// File: rtl/mips_mc_control_decode.sv
// Combinational state -> datapath control decode (Moore outputs).
//   state : current FSM state
//   ctrl  : control strobes; everything not set for a state is 0, and the
//           unused codes 12-15 decode to all-zero.
module mips_mc_ctrl_decode
   import mips_mc_control_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.memRead  = 1'b1;
            ctrl.irWrite  = 1'b1;
            ctrl.pcWrite  = 1'b1;
            ctrl.iorD     = 1'b0;
            ctrl.aluSrcA  = 1'b0;
            ctrl.aluSrcB  = SRCB_FOUR;
            ctrl.aluOp    = ALUOP_ADD;
            ctrl.pcSource = PCSRC_ALU;
         end
         S_DECODE: begin
            // branch target precomputed into ALUOut while regs are read
            ctrl.regRead = 1'b1;
            ctrl.aluSrcA = 1'b0;
            ctrl.aluSrcB = SRCB_IMM_SH2;
            ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.memRead = 1'b1;
            ctrl.iorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.memtoReg  = 1'b1;
            ctrl.regDst    = 1'b0;
            ctrl.instrDone = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.memWrite  = 1'b1;
            ctrl.iorD      = 1'b1;
            ctrl.instrDone = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_REGB;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = 1'b1;
            ctrl.memtoReg  = 1'b0;
            ctrl.instrDone = 1'b1;
         end
         S_BRANCH: begin
            ctrl.pcWriteCond = 1'b1;
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluSrcB     = SRCB_REGB;
            ctrl.aluOp       = ALUOP_SUB;
            ctrl.pcSource    = PCSRC_ALUOUT;
            ctrl.instrDone   = 1'b1;
         end
         S_JUMP: begin
            ctrl.pcWrite   = 1'b1;
            ctrl.pcSource  = PCSRC_JUMP;
            ctrl.instrDone = 1'b1;
         end
         S_ADDI_WB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = 1'b0;
            ctrl.memtoReg  = 1'b0;
            ctrl.instrDone = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces every output (and state) to 0
//           while high, next state FETCH
//   bus   : control interface (master side), opcode in, controls out
// ADDI_EN selects whether addi is decoded or treated as illegal.
module mips_mc_control
   import mips_mc_control_pkg::*;
#(
   parameter bit ADDI_EN = 1'b1
) (
   input logic              clk,
   input logic              reset,
   mips_mc_control_if.master bus
);

   state_t stateQ, stateD;
   ctrl_t  ctrl, ctrlOut;
   logic   opLegal;

   assign opLegal = isLegal(bus.opcode, ADDI_EN);

   always_ff @(posedge clk) begin
      if (reset) stateQ <= S_FETCH;
      else       stateQ <= stateD;
   end

   // opcode only steers the FSM in DECODE and MEM_ADDR
   always_comb begin
      stateD = S_FETCH;
      case (stateQ)
         S_FETCH: stateD = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     stateD = S_EXECUTE;
               OP_LW, OP_SW: stateD = S_MEM_ADDR;
               OP_BEQ:       stateD = S_BRANCH;
               OP_J:         stateD = S_JUMP;
               OP_ADDI:      stateD = ADDI_EN ? S_ADDI_EX : S_FETCH;
               default:      stateD = S_FETCH;
            endcase
         end
         S_MEM_ADDR: stateD = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: stateD = S_MEM_WB;
         S_EXECUTE:  stateD = S_ALU_WB;
         S_ADDI_EX:  stateD = S_ADDI_WB;
         default:    stateD = S_FETCH;
      endcase
   end

   mips_mc_ctrl_decode uDecode (
      .state (stateQ),
      .ctrl  (ctrl)
   );

   // Combinational gating makes reset kill the strobes in the same cycle,
   // so an instruction aborted by reset issues no write or done pulse.
   assign ctrlOut = reset ? '0 : ctrl;

   assign bus.state       = reset ? 4'd0 : stateQ;
   assign bus.illegal_op  = !reset && (stateQ == S_DECODE) && !opLegal;
   assign bus.PCWrite     = ctrlOut.pcWrite;
   assign bus.PCWriteCond = ctrlOut.pcWriteCond;
   assign bus.PCSource    = ctrlOut.pcSource;
   assign bus.IorD        = ctrlOut.iorD;
   assign bus.MemRead     = ctrlOut.memRead;
   assign bus.MemWrite    = ctrlOut.memWrite;
   assign bus.IRWrite     = ctrlOut.irWrite;
   assign bus.RegRead     = ctrlOut.regRead;
   assign bus.RegWrite    = ctrlOut.regWrite;
   assign bus.RegDst      = ctrlOut.regDst;
   assign bus.MemtoReg    = ctrlOut.memtoReg;
   assign bus.ALUSrcA     = ctrlOut.aluSrcA;
   assign bus.ALUSrcB     = ctrlOut.aluSrcB;
   assign bus.ALUOp       = ctrlOut.aluOp;
   assign bus.instr_done  = ctrlOut.instrDone;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle vector table of
// {reset, opcode, expected state, expected control word}, plus hand
// sequences for reset abort and the ADDI_EN=0 variant.
module tb_mips_mc_control;

   // control word bit order:
   // PCWrite PCWriteCond PCSource[1:0] IorD MemRead MemWrite IRWrite
   // RegRead RegWrite RegDst MemtoReg ALUSrcA ALUSrcB[1:0] ALUOp[1:0]
   // instr_done illegal_op
   localparam logic [18:0] W_ZERO  = 19'b0_0_00_0_0_0_0_0_0_0_0_0_00_00_0_0;
   localparam logic [18:0] W_FETCH = 19'b1_0_00_0_1_0_1_0_0_0_0_0_01_00_0_0;
   localparam logic [18:0] W_DEC   = 19'b0_0_00_0_0_0_0_1_0_0_0_0_11_00_0_0;
   localparam logic [18:0] W_DECIL = 19'b0_0_00_0_0_0_0_1_0_0_0_0_11_00_0_1;
   localparam logic [18:0] W_MADDR = 19'b0_0_00_0_0_0_0_0_0_0_0_1_10_00_0_0;
   localparam logic [18:0] W_MREAD = 19'b0_0_00_1_1_0_0_0_0_0_0_0_00_00_0_0;
   localparam logic [18:0] W_MWB   = 19'b0_0_00_0_0_0_0_0_1_0_1_0_00_00_1_0;
   localparam logic [18:0] W_MWR   = 19'b0_0_00_1_0_1_0_0_0_0_0_0_00_00_1_0;
   localparam logic [18:0] W_EXE   = 19'b0_0_00_0_0_0_0_0_0_0_0_1_00_10_0_0;
   localparam logic [18:0] W_AWB   = 19'b0_0_00_0_0_0_0_0_1_1_0_0_00_00_1_0;
   localparam logic [18:0] W_BR    = 19'b0_1_01_0_0_0_0_0_0_0_0_1_00_01_1_0;
   localparam logic [18:0] W_JMP   = 19'b1_0_10_0_0_0_0_0_0_0_0_0_00_00_1_0;
   localparam logic [18:0] W_AIEX  = 19'b0_0_00_0_0_0_0_0_0_0_0_1_10_00_0_0;
   localparam logic [18:0] W_AIWB  = 19'b0_0_00_0_0_0_0_0_1_0_0_0_00_00_1_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [18:0] w;
      string       nm;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   nPass = 0;
   int   nTot  = 0;
   vec_t vecs[$];

   mips_mc_control_if bus ();
   mips_mc_control_if bus2 ();

   mips_mc_control #(.ADDI_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
   mips_mc_control #(.ADDI_EN(1'b0)) dutNoAddi (.clk(clk), .reset(reset), .bus(bus2));

   always #5 clk = ~clk;

   logic [18:0] actW, actW2;
   assign actW = {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
                  bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegRead,
                  bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.instr_done, bus.illegal_op};
   assign actW2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.PCSource, bus2.IorD,
                   bus2.MemRead, bus2.MemWrite, bus2.IRWrite, bus2.RegRead,
                   bus2.RegWrite, bus2.RegDst, bus2.MemtoReg, bus2.ALUSrcA,
                   bus2.ALUSrcB, bus2.ALUOp, bus2.instr_done, bus2.illegal_op};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nTot++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic void addV(input logic r, input logic [5:0] op,
                                input logic [3:0] st, input logic [18:0] w,
                                input string nm);
      vec_t v;
      v.rst = r; v.op = op; v.st = st; v.w = w; v.nm = nm;
      vecs.push_back(v);
   endfunction

   // drive one cycle's inputs just after a falling edge, settle, then check
   task automatic cycleCheck(input logic r, input logic [5:0] op,
                             input logic [3:0] st, input logic [18:0] w,
                             input string nm);
      reset = r;
      bus.opcode = op;
      #1;
      chk({nm, "_state"}, {28'd0, bus.state}, {28'd0, st});
      chk({nm, "_ctrl"},  {13'd0, actW}, {13'd0, w});
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      bus.opcode  = LW;
      bus2.opcode = ADDI;

      addV(1, LW, 0, W_ZERO, "rst0");
      addV(1, LW, 0, W_ZERO, "rst1");
      // lw, opcode wiggled after MEM_ADDR must not matter
      addV(0, LW, 0, W_FETCH, "lw_f");
      addV(0, LW, 1, W_DEC,   "lw_d");
      addV(0, LW, 2, W_MADDR, "lw_ma");
      addV(0, SW, 3, W_MREAD, "lw_mr");
      addV(0, BAD, 4, W_MWB,  "lw_wb");
      // R-type, beq, j back to back
      addV(0, RT, 0, W_FETCH, "r_f");
      addV(0, RT, 1, W_DEC,   "r_d");
      addV(0, RT, 6, W_EXE,   "r_ex");
      addV(0, RT, 7, W_AWB,   "r_wb");
      addV(0, BEQ, 0, W_FETCH, "beq_f");
      addV(0, BEQ, 1, W_DEC,   "beq_d");
      addV(0, BEQ, 8, W_BR,    "beq_br");
      addV(0, JMP, 0, W_FETCH, "j_f");
      addV(0, JMP, 1, W_DEC,   "j_d");
      addV(0, JMP, 9, W_JMP,   "j_j");
      // sw
      addV(0, SW, 0, W_FETCH, "sw_f");
      addV(0, SW, 1, W_DEC,   "sw_d");
      addV(0, SW, 2, W_MADDR, "sw_ma");
      addV(0, SW, 5, W_MWR,   "sw_mw");
      // addi
      addV(0, ADDI, 0,  W_FETCH, "ai_f");
      addV(0, ADDI, 1,  W_DEC,   "ai_d");
      addV(0, ADDI, 10, W_AIEX,  "ai_ex");
      addV(0, ADDI, 11, W_AIWB,  "ai_wb");
      // illegal opcode
      addV(0, BAD, 0, W_FETCH, "il_f");
      addV(0, BAD, 1, W_DECIL, "il_d");
      addV(0, RT,  0, W_FETCH, "il_back");

      foreach (vecs[i])
         cycleCheck(vecs[i].rst, vecs[i].op, vecs[i].st, vecs[i].w, vecs[i].nm);

      // reset asserted in MEM_READ of lw aborts it
      cycleCheck(1, LW, 0, W_ZERO, "pre_rst");
      cycleCheck(0, LW, 0, W_FETCH, "ab_f");
      cycleCheck(0, LW, 1, W_DEC,   "ab_d");
      cycleCheck(0, LW, 2, W_MADDR, "ab_ma");
      cycleCheck(1, LW, 0, W_ZERO,  "ab_rst");
      cycleCheck(0, LW, 0, W_FETCH, "ab_after");

      // ADDI_EN=0: addi goes through DECODE as illegal and back to FETCH
      reset = 1'b1;
      #1;
      chk("na_rst_state", {28'd0, bus2.state}, 32'd0);
      chk("na_rst_ctrl",  {13'd0, actW2}, {13'd0, W_ZERO});
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("na_f_state", {28'd0, bus2.state}, 32'd0);
      chk("na_f_ctrl",  {13'd0, actW2}, {13'd0, W_FETCH});
      @(negedge clk);
      #1;
      chk("na_d_state", {28'd0, bus2.state}, 32'd1);
      chk("na_d_ctrl",  {13'd0, actW2}, {13'd0, W_DECIL});
      @(negedge clk);
      #1;
      chk("na_back_state", {28'd0, bus2.state}, 32'd0);
      chk("na_back_ctrl",  {13'd0, actW2}, {13'd0, W_FETCH});
      @(negedge clk);

      $display("%0d/%0d checks passed", nPass, nTot);
      $finish;
   end

endmodule
